// File: rtl/bch_chien_search_pkg.sv
// BCH Chien search shared definitions: FSM states and
// constant GF(2^M) helpers used to build the fixed multipliers.
package bch_chien_search_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Primitive field polynomial for GF(2^m), including the x^m term.
    function automatic int bch_poly(input int m);
        int p;
        case (m)
            2:       p = 'h7;
            3:       p = 'hB;
            4:       p = 'h13;
            5:       p = 'h25;
            6:       p = 'h43;
            7:       p = 'h89;
            8:       p = 'h11D;
            9:       p = 'h211;
            10:      p = 'h409;
            11:      p = 'h805;
            12:      p = 'h1053;
            13:      p = 'h201B;
            14:      p = 'h4443;
            15:      p = 'h8003;
            default: p = 'h13;
        endcase
        return p;
    endfunction

    // alpha^e in standard basis, as an integer bit pattern.
    function automatic int lpow(input int m, input int e);
        int r;
        int p;
        int ord;
        p   = bch_poly(m);
        ord = (1 << m) - 1;
        r   = 1;
        for (int i = 0; i < (e % ord); i++) begin
            r = r << 1;
            if (((r >> m) & 1) != 0) r = r ^ p;
        end
        return r;
    endfunction

endpackage

// File: rtl/bch_chien_search_reg.sv
// One locator term r_k: loads sigma_k*alpha^(k*S) and steps
// by alpha^k per enabled cycle, both as constant multiplies.
module bch_chien_search_reg
    import bch_chien_search_pkg::*;
#(
    parameter int M = 4,
    parameter int K = 0,
    parameter int S = 0
) (
    input  logic         clk,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic         step_i,
    input  logic [M-1:0] coef_i,
    output logic [M-1:0] r_o
);

    localparam logic [M-1:0] POLY   = M'(bch_poly(M));
    localparam logic [M-1:0] LOAD_C = M'(lpow(M, K * S));
    localparam logic [M-1:0] STEP_C = M'(lpow(M, K));

    function automatic logic [M-1:0] parallel_standard_multiplier(
        input logic [M-1:0] a,
        input logic [M-1:0] b
    );
        logic [M-1:0] p;
        logic [M-1:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) p = p ^ x;
            x = x[M-1] ? ((x << 1) ^ POLY) : (x << 1);
        end
        return p;
    endfunction

    logic [M-1:0] r_q;
    logic [M-1:0] r_d;

    // Next term value: fresh load wins over the per-index step.
    always_comb begin
        r_d = r_q;
        if (load_i) begin
            r_d = parallel_standard_multiplier(coef_i, LOAD_C);
        end else if (step_i) begin
            r_d = parallel_standard_multiplier(r_q, STEP_C);
        end
    end

    // Term register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset_i) r_q <= '0;
        else         r_q <= r_d;
    end

    assign r_o = r_q;

endmodule

// File: rtl/bch_chien_search.sv
// BCH Chien search: evaluates sigma(x) at alpha^(S+c) per index,
// flags roots as error bits, then reports root count and failure.
module bch_chien_search
    import bch_chien_search_pkg::*;
#(
    parameter int M = 4,
    parameter int N = (1 << M) - 1,
    parameter int T = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [M*(T+1)-1:0]     sigma,
    input  logic                   ce,
    output logic                   busy,
    output logic                   err_valid,
    output logic                   err_bit,
    output logic                   err_last,
    output logic                   done,
    output logic [$clog2(T+1):0]   err_count,
    output logic                   fail
);

    localparam int S   = (1 << M) - 1 - N;
    localparam int CIW = (N > 1) ? $clog2(N) : 1;
    localparam int CW  = $clog2(T + 1) + 1;

    state_e         state_q, state_d;
    logic [CIW-1:0] c_q, c_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  deg_q, deg_d;
    logic           z0_q, z0_d;
    logic           busy_q, busy_d;
    logic           ev_q, ev_d;
    logic           eb_q, eb_d;
    logic           el_q, el_d;
    logic           done_q, done_d;
    logic [CW-1:0]  ec_q, ec_d;
    logic           fail_q, fail_d;

    logic           load;
    logic           step;
    logic           root;
    logic [M-1:0]   sum;
    logic [CW-1:0]  sig_deg;
    logic [M-1:0]   r [T+1];

    // A restart is refused while the done pulse is still showing.
    assign load = (state_q == IDLE) && start && !done_q;
    assign step = (state_q == RUN) && ce;

    for (genvar k = 0; k <= T; k++) begin : g_reg
        bch_chien_search_reg #(
            .M (M),
            .K (k),
            .S (S)
        ) u_reg (
            .clk     (clk),
            .reset_i (reset),
            .load_i  (load),
            .step_i  (step),
            .coef_i  (sigma[k*M +: M]),
            .r_o     (r[k])
        );
    end

    // Locator value at the current point and degree of the input sigma.
    always_comb begin
        sum     = '0;
        sig_deg = '0;
        for (int k = 0; k <= T; k++) begin
            sum = sum ^ r[k];
            if (sigma[k*M +: M] != '0) sig_deg = CW'(k);
        end
        root = (sum == '0);
    end

    // FSM next state and output register updates.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        deg_d   = deg_q;
        z0_d    = z0_q;
        busy_d  = busy_q;
        ev_d    = ev_q;
        eb_d    = eb_q;
        el_d    = el_q;
        done_d  = done_q;
        ec_d    = ec_q;
        fail_d  = fail_q;
        if (ce) begin
            ev_d   = 1'b0;
            el_d   = 1'b0;
            done_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    deg_d   = sig_deg;
                    z0_d    = (sigma[M-1:0] == '0);
                    cnt_d   = '0;
                    c_d     = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (ce) begin
                    ev_d = 1'b1;
                    eb_d = root;
                    el_d = (c_q == CIW'(N - 1));
                    c_d  = c_q + CIW'(1);
                    if (root && (cnt_q != '1)) cnt_d = cnt_q + CW'(1);
                    if (c_q == CIW'(N - 1)) state_d = DONE;
                end
            end
            DONE: begin
                if (ce) begin
                    done_d  = 1'b1;
                    ec_d    = cnt_q;
                    fail_d  = z0_q | (cnt_q != deg_q);
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            c_q     <= '0;
            cnt_q   <= '0;
            deg_q   <= '0;
            z0_q    <= 1'b0;
            busy_q  <= 1'b0;
            ev_q    <= 1'b0;
            eb_q    <= 1'b0;
            el_q    <= 1'b0;
            done_q  <= 1'b0;
            ec_q    <= '0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            deg_q   <= deg_d;
            z0_q    <= z0_d;
            busy_q  <= busy_d;
            ev_q    <= ev_d;
            eb_q    <= eb_d;
            el_q    <= el_d;
            done_q  <= done_d;
            ec_q    <= ec_d;
            fail_q  <= fail_d;
        end
    end

    assign busy      = busy_q;
    assign err_valid = ev_q;
    assign err_bit   = eb_q;
    assign err_last  = el_q;
    assign done      = done_q;
    assign err_count = ec_q;
    assign fail      = fail_q;

endmodule

// File: tb/tb_bch_chien_search.sv
// Directed bench for bch_chien_search: full-length (N=15) and
// shortened (N=10) instances driven from a vector table.
module tb_bch_chien_search;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start;
    logic        ce;
    logic        sel10;
    logic [11:0] sigma;

    logic       b15, v15, e15, l15, d15, f15;
    logic [2:0] c15;
    logic       b10, v10, e10, l10, d10, f10;
    logic [2:0] c10;

    bch_chien_search #(.M(4), .N(15), .T(2)) dut15 (
        .clk       (clk),
        .reset     (reset),
        .start     (start & ~sel10),
        .sigma     (sigma),
        .ce        (ce),
        .busy      (b15),
        .err_valid (v15),
        .err_bit   (e15),
        .err_last  (l15),
        .done      (d15),
        .err_count (c15),
        .fail      (f15)
    );

    bch_chien_search #(.M(4), .N(10), .T(2)) dut10 (
        .clk       (clk),
        .reset     (reset),
        .start     (start & sel10),
        .sigma     (sigma),
        .ce        (ce),
        .busy      (b10),
        .err_valid (v10),
        .err_bit   (e10),
        .err_last  (l10),
        .done      (d10),
        .err_count (c10),
        .fail      (f10)
    );

    logic       b_m, v_m, e_m, l_m, d_m, f_m;
    logic [2:0] c_m;
    assign b_m = sel10 ? b10 : b15;
    assign v_m = sel10 ? v10 : v15;
    assign e_m = sel10 ? e10 : e15;
    assign l_m = sel10 ? l10 : l15;
    assign d_m = sel10 ? d10 : d15;
    assign f_m = sel10 ? f10 : f15;
    assign c_m = sel10 ? c10 : c15;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    typedef struct {
        logic        sel;
        logic [11:0] sg;
        int          mask;
        int          n;
        int          cnt;
        int          fl;
        int          hold_at;
        int          start_at;
    } vec_t;

    vec_t vt[9];

    task automatic run_vec(input vec_t v);
        int   beats;
        int   lastidx;
        int   mask;
        int   snap;
        bit   got;
        int   cnt;
        int   fl;
        sel10 = v.sel;
        @(negedge clk);
        start = 1'b0;
        ce    = 1'b1;
        @(negedge clk);
        sigma = v.sg;
        start = 1'b1;
        beats   = 0;
        lastidx = -1;
        mask    = 0;
        got     = 1'b0;
        cnt     = -1;
        fl      = -1;
        for (int cyc = 0; cyc < 60 && !got; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (v_m) begin
                if (beats < 31 && e_m) mask = mask | (1 << beats);
                if (l_m) lastidx = beats;
                beats++;
                if (beats == v.start_at) begin
                    sigma = 12'h000;
                    start = 1'b1;
                end
                if (beats == v.hold_at) begin
                    ce   = 1'b0;
                    snap = int'({v_m, e_m, l_m, b_m, d_m});
                    for (int h = 0; h < 3; h++) begin
                        @(negedge clk);
                        check("hold_freeze", int'({v_m, e_m, l_m, b_m, d_m}), snap);
                    end
                    ce = 1'b1;
                end
            end
            if (d_m) begin
                got = 1'b1;
                cnt = int'(c_m);
                fl  = int'(f_m);
            end
        end
        check("done_seen", int'(got), 1);
        check("err_mask", mask, v.mask);
        check("beats", beats, v.n);
        check("last_idx", lastidx, v.n - 1);
        check("err_count", cnt, v.cnt);
        check("fail", fl, v.fl);
    endtask

    initial begin
        int  beats;
        bit  seen;

        vt[0] = '{1'b0, 12'h001, 32'h0000, 15, 0, 0, -1, -1};
        vt[1] = '{1'b0, 12'h081, 32'h1000, 15, 1, 0, -1, -1};
        vt[2] = '{1'b0, 12'hB21, 32'h2400, 15, 2, 0, -1, -1};
        vt[3] = '{1'b0, 12'h101, 32'h0001, 15, 1, 1, -1, -1};
        vt[4] = '{1'b0, 12'h020, 32'h0000, 15, 0, 1, -1, -1};
        vt[5] = '{1'b0, 12'h000, 32'h7FFF, 15, 7, 1, -1, -1};
        vt[6] = '{1'b0, 12'h021, 32'h4000, 15, 1, 0, -1, -1};
        vt[7] = '{1'b1, 12'h081, 32'h0080, 10, 1, 0,  4, -1};
        vt[8] = '{1'b0, 12'hB21, 32'h2400, 15, 2, 0, -1,  4};

        reset = 1'b1;
        start = 1'b1;
        ce    = 1'b0;
        sel10 = 1'b0;
        sigma = 12'h081;
        repeat (3) @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        check("rst_busy", int'({b15, b10}), 0);
        check("rst_valid", int'({v15, v10, l15, l10}), 0);
        check("rst_done", int'({d15, d10}), 0);
        check("rst_count15", int'(c15), 0);
        check("rst_count10", int'(c10), 0);
        check("rst_fail", int'({f15, f10}), 0);

        for (int i = 0; i < 9; i++) run_vec(vt[i]);

        sel10 = 1'b0;
        @(negedge clk);
        start = 1'b0;
        ce    = 1'b1;
        @(negedge clk);
        sigma = 12'h081;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        beats = 0;
        for (int cyc = 0; cyc < 40 && beats < 6; cyc++) begin
            @(negedge clk);
            if (v15) beats++;
        end
        check("rst_reach_c6", beats, 6);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", int'(b15), 0);
        check("midrst_valid", int'({v15, l15}), 0);
        seen = 1'b0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            @(negedge clk);
            if (d15 || v15 || b15) seen = 1'b1;
        end
        check("midrst_no_done", int'(seen), 0);

        run_vec(vt[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bch_chien_search.md
Name: bch_chien_search

Overview:
- Error-location stage of the BCH decoder.
- Sits directly downstream of the error-locator (key-equation) solver and upstream of the correction XOR.
- Latches the locator polynomial sigma(x) = sigma_0 + sigma_1*x + ... + sigma_T*x^T (standard basis, GF(2^M)), then evaluates it at one field point per enabled cycle.
- Emits one error flag per codeword bit, followed by a root count and a fail flag when done.

Parameters:
- M, 4, field degree GF(2^M); field polynomial per BCH_POLYNOMIAL(M).
- N, 2^M-1, codeword length in bits (N < 2^M-1 means shortened code).
- T, 2, correction capability; number of sigma coefficients is T+1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  load sigma and begin a search; accepted only when busy=0
- sigma  in  M*(T+1)  coefficients, sigma_k at [k*M+:M], standard basis; sampled only on accepted start
- ce  in  1  downstream enable; when 0, all state and outputs hold
- busy  out  1  search in progress (start ignored)
- err_valid  out  1  err_bit is valid this cycle
- err_bit  out  1  1 = codeword bit at index c is in error
- err_last  out  1  qualifies err_valid on final index c=N-1
- done  out  1  single-cycle pulse after last index; err_count/fail valid while done=1
- err_count  out  log2(T+1)+1  number of roots found, saturating at 2^width-1
- fail  out  1  uncorrectable: err_count != deg(sigma), or sigma_0 == 0

Behaviour:
- Reset: busy, err_valid, err_bit, err_last, done, fail = 0; err_count = 0; FSM = IDLE. Reset overrides start and ce and aborts a search mid-run; no done pulse is produced.
- Shortening offset S = 2^M-1-N.
- Evaluation point for index c (0..N-1) is x_c = alpha^(S+c).
- err_bit[c] = 1 iff sum_k sigma_k*x_c^k == 0.
- FSM IDLE:
  - start=1 (ce ignored): load r_k <= sigma_k*alpha^(k*S) via compile-time constant multipliers.
  - Latch deg = highest k with sigma_k != 0 (deg=0 if only sigma_0 is nonzero).
  - Latch z0 = (sigma_0 == 0). Clear the root counter. Set busy=1. Go to RUN.
- FSM RUN, each cycle with ce=1:
  - err_valid <= 1; err_bit <= (XOR of all r_k == 0); err_last <= (c == N-1).
  - r_k <= r_k*alpha^k (constant multiplier). c <= c+1. Counter increments on a root.
- RUN, after c=N-1 is issued with ce=1: go to DONE.
- FSM DONE, first ce=1 cycle:
  - done <= 1; err_count <= final count; fail <= z0 | (count != deg).
  - busy <= 0; go to IDLE.
- Output registers pulse for one ce-qualified cycle. When ce=0, err_valid/done hold their last value and nothing advances; downstream samples only on ce=1.
- Latency: start accepted in cycle t; index 0 on err_valid at t+1 (first ce=1 in RUN); done one ce-cycle after err_last.
- Total: N+1 enabled cycles per search after load.
- start while busy=1 is ignored; sigma is not resampled.
- start in the same cycle as the done pulse is ignored. Earliest restart is the cycle after done.
- Root counter: the final index counts toward err_count. The counter saturates and never wraps.
- Arithmetic is XOR/AND only, no carries. The index counter c is a binary counter of width log2(N); it wraps only on reset or reload.

Decomposition:
- Shared package/header (bch.vh):
  - FSM state encodings IDLE/RUN/DONE.
  - Constant-exponent function used for the alpha^(k*S) and alpha^k multipliers (existing lpow).
- Natural sub-module: bch_chien_reg, one per coefficient k. It holds r_k, applies the load constant multiply on start and the alpha^k step multiply on ce, and is built on parallel_standard_multiplier.

Test Plan:
- M=4,N=15,T=2, sigma={0,0,1}, start -> 15 err_valid beats, all err_bit=0, err_last on 15th, done with err_count=0, fail=0.
- sigma_0=1, sigma_1=alpha^3 (0x8), sigma_2=0 -> err_bit=1 only at c=12; err_count=1, fail=0.
- sigma = 1 + alpha*x + alpha^7*x^2 (sigma_1=0x2, sigma_2=0xB) -> err_bit at c=10 and c=13 only; err_count=2, fail=0.
- sigma = 1 + x^2 (repeated root) -> err_bit at c=0 only; err_count=1, deg=2 -> fail=1. Separately, sigma_0=0 -> fail=1.
- N=10 (S=5), sigma = 1 + alpha^3*x -> err_bit at c=7 only. Toggle ce low for 3 cycles mid-run -> outputs frozen, same sequence resumes.
- Assert start at c=4 -> ignored, results unchanged. Assert reset at c=6 -> busy=0, no done. A new start then runs a full N-index search.
